// File: rtl/vscale_dmem_bridge.sv
// Bridges the vscale dmem port (address phase, then data phase) to the req/ack data bus.
// Stores are posted through a small write buffer; reads wait until the buffer has drained.
module vscale_dmem_bridge #(
  parameter int ADDR_W     = 32,
  parameter int WB_DEPTH   = 4,
  parameter int NC_REGIONS = 2,
  parameter logic [32*NC_REGIONS-1:0] NC_BASE = {NC_REGIONS{32'h0000_0000}},
  parameter logic [32*NC_REGIONS-1:0] NC_MASK = {NC_REGIONS{32'h0000_ffff}},
  localparam int PTR_W = $clog2(WB_DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              dmem_en,
  input  logic              dmem_wen,
  input  logic [2:0]        dmem_size,
  input  logic [ADDR_W-1:0] dmem_addr,
  input  logic [ADDR_W-1:0] dmem_wdata,
  output logic              dmem_wait,
  output logic [ADDR_W-1:0] dmem_rdata,
  output logic              d_req_val,
  output logic [ADDR_W-1:0] d_req_addr,
  output logic [2:0]        d_req_cop,
  output logic [ADDR_W-1:0] d_req_wdata,
  output logic [2:0]        d_req_size,
  input  logic              d_req_ack,
  input  logic [ADDR_W-1:0] d_ack_rdata,
  output logic              wb_empty,
  output logic [CNT_W-1:0]  wb_count
);

  logic [ADDR_W-1:0] fifo_addr_q [WB_DEPTH];
  logic [ADDR_W-1:0] fifo_data_q [WB_DEPTH];
  logic [2:0]        fifo_size_q [WB_DEPTH];
  logic              fifo_nc_q   [WB_DEPTH];

  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              pend_q, pend_nc_q;
  logic [ADDR_W-1:0] pend_addr_q;
  logic [2:0]        pend_size_q;

  // Last presented request fields, shown on the bus while it is idle.
  logic [ADDR_W-1:0] hold_addr_q, hold_wdata_q;
  logic [2:0]        hold_size_q, hold_cop_q;

  logic [ADDR_W-1:0] req_addr, req_wdata;
  logic [2:0]        req_size, req_cop;
  logic              addr_nc, fifo_nonempty, wb_full, rd_issue, wr_accept, push, pop;

  // NOTE: every signal written in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    addr_nc = 1'b0;
    for (int i = 0; i < NC_REGIONS; i++) begin
      if ((dmem_addr & ~ADDR_W'(NC_MASK[32*i +: 32])) == ADDR_W'(NC_BASE[32*i +: 32]))
        addr_nc = 1'b1;
    end
  end

  assign fifo_nonempty = (count_q != '0);
  assign wb_count      = count_q + CNT_W'(pend_q);
  assign wb_empty      = ~fifo_nonempty & ~pend_q;
  assign wb_full       = (wb_count == CNT_W'(WB_DEPTH));
  assign rd_issue      = rst_n & dmem_en & ~dmem_wen & wb_empty;
  assign wr_accept     = rst_n & dmem_en & dmem_wen & ~wb_full;
  assign push          = pend_q;
  assign pop           = fifo_nonempty & d_req_ack;
  assign dmem_rdata    = d_ack_rdata;

  always_comb begin
    dmem_wait = 1'b0;
    if (rst_n && dmem_en)
      dmem_wait = dmem_wen ? wb_full : ~(wb_empty & d_req_ack);
  end

  // Buffered writes always win the bus; a pending entry has no data yet and is never issued.
  always_comb begin
    d_req_val = fifo_nonempty | rd_issue;
    req_addr  = hold_addr_q;
    req_wdata = hold_wdata_q;
    req_size  = hold_size_q;
    req_cop   = hold_cop_q;
    if (fifo_nonempty) begin
      req_addr  = fifo_addr_q[rd_ptr_q];
      req_wdata = fifo_data_q[rd_ptr_q];
      req_size  = fifo_size_q[rd_ptr_q];
      req_cop   = {1'b0, fifo_nc_q[rd_ptr_q], 1'b1};
    end else if (rd_issue) begin
      req_addr  = dmem_addr;
      req_size  = dmem_size;
      req_cop   = {1'b0, addr_nc, 1'b0};
    end
  end

  assign d_req_addr  = req_addr;
  assign d_req_wdata = req_wdata;
  assign d_req_cop   = req_cop;
  assign d_req_size  = req_size << 1;

  always_comb begin
    count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
    wr_ptr_d = wr_ptr_q + PTR_W'(push);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop);
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      pend_q       <= 1'b0;
      pend_nc_q    <= 1'b0;
      pend_addr_q  <= '0;
      pend_size_q  <= '0;
      hold_addr_q  <= '0;
      hold_wdata_q <= '0;
      hold_size_q  <= '0;
      hold_cop_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      pend_q   <= wr_accept;
      if (wr_accept) begin
        pend_addr_q <= dmem_addr;
        pend_size_q <= dmem_size;
        pend_nc_q   <= addr_nc;
      end
      if (d_req_val) begin
        hold_addr_q  <= req_addr;
        hold_wdata_q <= req_wdata;
        hold_size_q  <= req_size;
        hold_cop_q   <= req_cop;
      end
    end
  end

  // NOTE: buffer storage is not reset; an entry only counts as valid through count_q.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr_q[wr_ptr_q] <= pend_addr_q;
      fifo_size_q[wr_ptr_q] <= pend_size_q;
      fifo_nc_q[wr_ptr_q]   <= pend_nc_q;
      fifo_data_q[wr_ptr_q] <= dmem_wdata;
    end
  end

endmodule

// File: tb/tb_vscale_dmem_bridge.sv
// Randomised and directed bench for vscale_dmem_bridge against a queue-based model of the
// posted write buffer, the read-drain rule and the non-cacheable decode.
module tb_vscale_dmem_bridge;
  localparam int ADDR_W     = 32;
  localparam int WB_DEPTH   = 4;
  localparam int NC_REGIONS = 2;
  localparam logic [63:0] NC_BASE = {32'h8000_0000, 32'h0000_0000};
  localparam logic [63:0] NC_MASK = {32'h0000_00ff, 32'h0000_ffff};

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        dmem_en = 1'b0, dmem_wen = 1'b0;
  logic [2:0]  dmem_size = '0;
  logic [31:0] dmem_addr = '0, dmem_wdata = '0;
  logic        dmem_wait;
  logic [31:0] dmem_rdata;
  logic        d_req_val;
  logic [31:0] d_req_addr, d_req_wdata;
  logic [2:0]  d_req_cop, d_req_size;
  logic        d_req_ack = 1'b0;
  logic [31:0] d_ack_rdata = '0;
  logic        wb_empty;
  logic [2:0]  wb_count;

  vscale_dmem_bridge #(
    .ADDR_W(ADDR_W), .WB_DEPTH(WB_DEPTH), .NC_REGIONS(NC_REGIONS),
    .NC_BASE(NC_BASE), .NC_MASK(NC_MASK)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .dmem_en(dmem_en), .dmem_wen(dmem_wen), .dmem_size(dmem_size),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_wait(dmem_wait), .dmem_rdata(dmem_rdata),
    .d_req_val(d_req_val), .d_req_addr(d_req_addr), .d_req_cop(d_req_cop),
    .d_req_wdata(d_req_wdata), .d_req_size(d_req_size),
    .d_req_ack(d_req_ack), .d_ack_rdata(d_ack_rdata),
    .wb_empty(wb_empty), .wb_count(wb_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [2:0]  size;
    logic        nc;
    logic [31:0] data;
  } wr_t;

  wr_t         wq[$];
  logic        m_pend = 1'b0;
  wr_t         m_pend_rec;
  logic [31:0] last_addr = '0;
  logic [2:0]  last_cop = '0, last_size = '0;
  int          n_checks = 0, n_errors = 0;
  int          ack_mode = 0;  // 0 never, 1 always, 2 random

  // Windows: 0x0000_xxxx (16 offset bits) and 0x8000_00xx (8 offset bits).
  function automatic logic nc_of(input logic [31:0] a);
    return (a[31:16] == 16'h0000) || (a[31:8] == 24'h80_0000);
  endfunction

  function automatic logic [2:0] bus_size(input logic [2:0] s);
    return 3'((int'(s) * 2) % 8);
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // One core cycle: drive at posedge+1, check at negedge, advance the model at posedge.
  task automatic step(input logic en, input logic wen, input logic [2:0] size,
                      input logic [31:0] addr, input logic [31:0] data, output logic stalled);
    logic        ack, empty, rd, exp_val, exp_wait;
    logic [31:0] ack_rd, e_addr;
    logic [2:0]  e_cop, e_size;
    int          occ;
    ack    = (ack_mode == 1) || (ack_mode == 2 && $urandom_range(0, 1) == 0);
    ack_rd = $urandom;
    dmem_en = en; dmem_wen = wen; dmem_size = size; dmem_addr = addr;
    dmem_wdata  = m_pend ? m_pend_rec.data : $urandom;
    d_req_ack   = ack;
    d_ack_rdata = ack_rd;
    #4;
    occ      = wq.size() + (m_pend ? 1 : 0);
    empty    = (occ == 0);
    rd       = en && !wen && empty;
    exp_val  = (wq.size() != 0) || rd;
    exp_wait = en && (wen ? (occ == WB_DEPTH) : !(empty && ack));
    check("d_req_val", 32'(d_req_val), 32'(exp_val));
    check("dmem_wait", 32'(dmem_wait), 32'(exp_wait));
    check("wb_count", 32'(wb_count), 32'(occ));
    check("wb_empty", 32'(wb_empty), 32'(empty));
    e_addr = last_addr; e_cop = last_cop; e_size = last_size;
    if (wq.size() != 0) begin
      e_addr = wq[0].addr;
      e_cop  = {1'b0, wq[0].nc, 1'b1};
      e_size = bus_size(wq[0].size);
      check("wr_wdata", d_req_wdata, wq[0].data);
    end else if (rd) begin
      e_addr = addr;
      e_cop  = {1'b0, nc_of(addr), 1'b0};
      e_size = bus_size(size);
      if (ack) check("rd_rdata", dmem_rdata, ack_rd);
    end
    check("d_req_addr", d_req_addr, e_addr);
    check("d_req_cop", 32'(d_req_cop), 32'(e_cop));
    check("d_req_size", 32'(d_req_size), 32'(e_size));
    if (exp_val) begin
      last_addr = e_addr; last_cop = e_cop; last_size = e_size;
    end
    @(posedge clk);
    if (wq.size() != 0 && ack) wq.delete(0);
    if (m_pend) wq.push_back(m_pend_rec);
    m_pend = 1'b0;
    if (en && wen && !exp_wait) begin
      m_pend     = 1'b1;
      m_pend_rec = '{addr: addr, size: size, nc: nc_of(addr), data: data};
    end
    stalled = exp_wait;
    #1;
  endtask

  task automatic access(input logic wen, input logic [2:0] size, input logic [31:0] addr,
                        input logic [31:0] data);
    logic stalled;
    int   n;
    stalled = 1'b1;
    n = 0;
    while (stalled && n < 200) begin
      step(1'b1, wen, size, addr, data, stalled);
      n++;
    end
    check("access_bound", 32'(stalled), 32'(0));
  endtask

  task automatic idle(input int n);
    logic s;
    repeat (n) step(1'b0, 1'b0, 3'd0, 32'h0, 32'h0, s);
  endtask

  task automatic drain();
    int n;
    ack_mode = 1;
    n = 0;
    while ((wq.size() != 0 || m_pend) && n < 64) begin
      idle(1);
      n++;
    end
    check("drain_bound", 32'(wq.size()), 32'(0));
  endtask

  task automatic do_reset();
    logic [31:0] r;
    r = $urandom;
    rst_n = 1'b0;
    dmem_en = 1'b0; dmem_wen = 1'b0; d_req_ack = 1'b0; d_ack_rdata = r;
    #1;
    check("rst_val", 32'(d_req_val), 32'(0));
    check("rst_wait", 32'(dmem_wait), 32'(0));
    check("rst_empty", 32'(wb_empty), 32'(1));
    check("rst_count", 32'(wb_count), 32'(0));
    check("rst_addr", d_req_addr, 32'h0);
    check("rst_cop", 32'(d_req_cop), 32'(0));
    check("rst_size", 32'(d_req_size), 32'(0));
    check("rst_wdata", d_req_wdata, 32'h0);
    check("rst_rdata", dmem_rdata, r);
    wq.delete();
    m_pend = 1'b0;
    last_addr = '0; last_cop = '0; last_size = '0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  function automatic logic [31:0] rand_addr();
    case ($urandom_range(0, 3))
      0:       return {16'h0000, 16'($urandom)};
      1:       return {24'h80_0000, 8'($urandom)};
      2:       return {24'h80_0001, 8'($urandom)};
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic st;
    #1;
    do_reset();

    // Single posted write, acked a few cycles later.
    ack_mode = 0;
    access(1'b1, 3'd2, 32'h0001_0040, 32'hDEAD_BEEF);
    idle(2);
    ack_mode = 1;
    idle(1);
    ack_mode = 0;
    idle(1);

    // Fill with the bus stalled: the fifth address phase must stall.
    for (int i = 0; i < 5; i++)
      step(1'b1, 1'b1, 3'd2, 32'h0002_0000 + 32'(i * 4), 32'h1111_0000 + 32'(i), st);
    ack_mode = 1;
    access(1'b1, 3'd2, 32'h0002_0010, 32'h1111_0004);
    drain();

    // Read-after-write to the same address.
    ack_mode = 2;
    access(1'b1, 3'd2, 32'h0000_0100, 32'hCAFE_F00D);
    access(1'b0, 3'd2, 32'h0000_0100, 32'h0);
    drain();

    // Non-cacheable decode on reads.
    ack_mode = 1;
    access(1'b0, 3'd2, 32'h0000_1234, 32'h0);
    access(1'b0, 3'd0, 32'h8000_0010, 32'h0);
    access(1'b0, 3'd1, 32'h0001_0000, 32'h0);
    access(1'b0, 3'd2, 32'h8000_0100, 32'h0);

    // Three buffered, then ten writes with a push and pop every cycle.
    ack_mode = 0;
    for (int i = 0; i < 3; i++) access(1'b1, 3'd2, 32'h0003_0000 + 32'(i * 4), $urandom);
    idle(1);
    ack_mode = 1;
    for (int i = 0; i < 10; i++) access(1'b1, 3'(i % 3), 32'h8000_0000 + 32'(i * 4), $urandom);
    drain();

    // Reset with two buffered writes and a live bus request.
    ack_mode = 0;
    access(1'b1, 3'd2, 32'h0004_0000, 32'h0A0A_0A0A);
    access(1'b1, 3'd2, 32'h0004_0004, 32'h0B0B_0B0B);
    idle(1);
    check("pre_rst_val", 32'(d_req_val), 32'(1));
    do_reset();
    idle(2);

    // Random traffic.
    ack_mode = 2;
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 3) == 0) idle(1);
      else access(1'($urandom_range(0, 1)), 3'($urandom_range(0, 2)), rand_addr(), $urandom);
    end
    drain();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
